// File: rtl/uart_cmd_pkg.sv
// Shared constants and encodings for the UART command-line parser.
// Holds the ASCII classes, command strings, command enum and parser state encoding.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;
  localparam logic [7:0] ASCII_SP       = 8'h20;
  localparam logic [7:0] ASCII_LC_LO    = 8'h61;
  localparam logic [7:0] ASCII_LC_HI    = 8'h7A;
  localparam logic [7:0] ASCII_PR_LO    = 8'h21;
  localparam logic [7:0] ASCII_PR_HI    = 8'h7E;
  localparam logic [7:0] ASCII_CASE_OFS = 8'h20;

  // Command strings are packed first-character-in-MSB, padded to CMD_STR_MAX bytes
  localparam int               CMD_STR_MAX = 3;
  localparam logic [23:0]      CMD_DHT_STR = "DHT";
  localparam int               CMD_DHT_LEN = 3;
  localparam logic [23:0]      CMD_SR_STR  = {"SR", 8'h00};
  localparam int               CMD_SR_LEN  = 2;
  localparam logic [23:0]      CMD_RST_STR = "RST";
  localparam int               CMD_RST_LEN = 3;

  typedef enum logic [1:0] {
    CMD_NONE = 2'd0,
    CMD_DHT  = 2'd1,
    CMD_SR04 = 2'd2,
    CMD_RST  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DISCARD = 2'd2,
    ST_DECODE  = 2'd3
  } state_e;

  function automatic logic [7:0] cmd_char(input logic [8*CMD_STR_MAX-1:0] str, input int idx);
    int k;
    k = (idx < CMD_STR_MAX) ? (CMD_STR_MAX - 1 - idx) : 0;
    return (idx < CMD_STR_MAX) ? str[8*k +: 8] : 8'h00;
  endfunction

endpackage

// File: rtl/uart_cmd_match.sv
// Combinational line matcher: compares the buffered line against the known commands.
// Length must match exactly; characters beyond the line length are ignored.
module uart_cmd_match
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN = 4,
  parameter int LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic [8*MAX_LEN-1:0] buf_i,
  input  logic [LEN_W-1:0]     len_i,
  output cmd_e                 cmd_o
);

  logic dht_ok;
  logic sr_ok;
  logic rst_ok;

  always_comb begin
    dht_ok = (len_i == LEN_W'(CMD_DHT_LEN));
    sr_ok  = (len_i == LEN_W'(CMD_SR_LEN));
    rst_ok = (len_i == LEN_W'(CMD_RST_LEN));
    for (int i = 0; i < MAX_LEN; i++) begin
      if (LEN_W'(i) < len_i) begin
        if (buf_i[8*i +: 8] != cmd_char(CMD_DHT_STR, i)) dht_ok = 1'b0;
        if (buf_i[8*i +: 8] != cmd_char(CMD_SR_STR, i))  sr_ok  = 1'b0;
        if (buf_i[8*i +: 8] != cmd_char(CMD_RST_STR, i)) rst_ok = 1'b0;
      end
    end
    if (dht_ok)      cmd_o = CMD_DHT;
    else if (sr_ok)  cmd_o = CMD_SR04;
    else if (rst_ok) cmd_o = CMD_RST;
    else             cmd_o = CMD_NONE;
  end

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles UART bytes into a short line, decodes it on CR/LF and issues one-cycle
// command strobes; malformed lines give cmd_err, stale partial lines time out silently.
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int MAX_LEN     = 4,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_done,
  output logic       cmd_dht,
  output logic       cmd_sr04,
  output logic       cmd_rst,
  output logic       cmd_err,
  output logic       busy
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  state_e               state_q, state_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [8*MAX_LEN-1:0] buf_q, buf_d;
  logic                 err_q, err_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 rx_done_q;
  logic [3:0]           strb_q, strb_d;   // {err, rst, sr04, dht}

  logic       accept;
  logic       is_term, is_space, is_lower, is_print, is_illegal;
  logic [7:0] ch_up;
  logic       tmo_hit;
  cmd_e       match;

  assign accept     = rx_done & ~rx_done_q;
  assign is_term    = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
  assign is_space   = (rx_data == ASCII_SP);
  assign is_lower   = (rx_data >= ASCII_LC_LO) && (rx_data <= ASCII_LC_HI);
  assign ch_up      = is_lower ? (rx_data - ASCII_CASE_OFS) : rx_data;
  assign is_print   = !is_term && !is_space && (ch_up >= ASCII_PR_LO) && (ch_up <= ASCII_PR_HI);
  assign is_illegal = !is_term && !is_space && !is_print;
  assign tmo_hit    = (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  uart_cmd_match #(
    .MAX_LEN (MAX_LEN),
    .LEN_W   (LEN_W)
  ) u_match (
    .buf_i (buf_q),
    .len_i (len_q),
    .cmd_o (match)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    buf_d   = buf_q;
    err_d   = err_q;
    tmo_d   = '0;
    strb_d  = '0;

    case (state_q)
      ST_DECODE: begin
        if (err_q) begin
          strb_d[3] = 1'b1;
        end else begin
          case (match)
            CMD_DHT:  strb_d[0] = 1'b1;
            CMD_SR04: strb_d[1] = 1'b1;
            CMD_RST:  strb_d[2] = 1'b1;
            default:  strb_d[3] = 1'b1;
          endcase
        end
        len_d   = '0;
        err_d   = 1'b0;
        state_d = ST_IDLE;
      end
      ST_COLLECT, ST_DISCARD: begin
        tmo_d = tmo_q + TMO_W'(1);
        // An accept in the expiry cycle takes priority over the timeout
        if (!accept && tmo_hit) begin
          tmo_d   = '0;
          len_d   = '0;
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: ;
    endcase

    if (accept) begin
      tmo_d = '0;
      case (state_q)
        ST_IDLE, ST_DECODE: begin
          if (is_print) begin
            buf_d[7:0] = ch_up;
            len_d      = LEN_W'(1);
            state_d    = ST_COLLECT;
          end else if (is_illegal) begin
            state_d = ST_DISCARD;
          end
        end
        ST_COLLECT: begin
          if (is_term) begin
            state_d = ST_DECODE;
          end else if (is_illegal) begin
            state_d = ST_DISCARD;
          end else if (is_print) begin
            if (len_q < LEN_W'(MAX_LEN)) begin
              for (int i = 0; i < MAX_LEN; i++) begin
                if (len_q == LEN_W'(i)) buf_d[8*i +: 8] = ch_up;
              end
              len_d = len_q + LEN_W'(1);
            end else begin
              state_d = ST_DISCARD;
            end
          end
        end
        ST_DISCARD: begin
          if (is_term) begin
            state_d = ST_DECODE;
            err_d   = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      buf_q     <= '0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
      rx_done_q <= 1'b0;
      strb_q    <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      buf_q     <= buf_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
      rx_done_q <= rx_done;
      strb_q    <= strb_d;
    end
  end

  assign cmd_dht  = strb_q[0];
  assign cmd_sr04 = strb_q[1];
  assign cmd_rst  = strb_q[2];
  assign cmd_err  = strb_q[3];
  assign busy     = (state_q == ST_COLLECT) || (state_q == ST_DISCARD);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: a line-level reference model predicts each
// strobe and its cycle; a negedge monitor pops and compares whenever a strobe appears.
module tb_uart_cmd_parser;

  localparam int MAX_LEN = 4;
  localparam int TO      = 50;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       cmd_dht, cmd_sr04, cmd_rst, cmd_err, busy;

  always #5 clk = ~clk;

  uart_cmd_parser #(
    .MAX_LEN     (MAX_LEN),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .cmd_dht  (cmd_dht),
    .cmd_sr04 (cmd_sr04),
    .cmd_rst  (cmd_rst),
    .cmd_err  (cmd_err),
    .busy     (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {EV_DHT = 0, EV_SR = 1, EV_RST = 2, EV_ERR = 3} ev_e;
  typedef struct {
    ev_e kind;
    int  at;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference model: the line as text, plus whether it is being thrown away
  logic [7:0] line[$];
  bit         partial;
  bit         disc;
  int         last_acc = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void model_reset();
    line.delete();
    partial = 1'b0;
    disc    = 1'b0;
  endfunction

  function automatic ev_e decode_line();
    if (line.size() == 3 && line[0] == "D" && line[1] == "H" && line[2] == "T") return EV_DHT;
    if (line.size() == 2 && line[0] == "S" && line[1] == "R") return EV_SR;
    if (line.size() == 3 && line[0] == "R" && line[1] == "S" && line[2] == "T") return EV_RST;
    return EV_ERR;
  endfunction

  task automatic model_byte(input logic [7:0] b, input int c);
    logic [7:0] u;
    ev_t        e;
    if (partial && (c - last_acc) > TO) model_reset();
    last_acc = c;
    if (b == 8'h0D || b == 8'h0A) begin
      if (disc || line.size() > 0) begin
        e.kind = disc ? EV_ERR : decode_line();
        e.at   = c + 2;
        exp_q.push_back(e);
      end
      model_reset();
    end else if (b != 8'h20) begin
      u = (b >= 8'h61 && b <= 8'h7A) ? b - 8'h20 : b;
      partial = 1'b1;
      if (u < 8'h21 || u > 8'h7E) disc = 1'b1;
      else if (!disc) begin
        if (line.size() < MAX_LEN) line.push_back(u);
        else disc = 1'b1;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int hold, input int gap);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    model_byte(b, cyc);
    repeat (hold) @(negedge clk);
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_str(input string s, input int hold, input int gap);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], hold, gap);
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_cmd_dht"}, int'(cmd_dht), 0);
    check({tag, "_cmd_sr04"}, int'(cmd_sr04), 0);
    check({tag, "_cmd_rst"}, int'(cmd_rst), 0);
    check({tag, "_cmd_err"}, int'(cmd_err), 0);
    check({tag, "_busy"}, int'(busy), 0);
  endtask

  // Monitor: every strobe must match the next predicted event
  int  mon_n;
  int  mon_kind;
  ev_t mon_e;
  always @(negedge clk) begin
    if (!reset) begin
      mon_n = int'(cmd_dht) + int'(cmd_sr04) + int'(cmd_rst) + int'(cmd_err);
      if (mon_n > 0) begin
        if (mon_n > 1) check("one_hot_strobe", mon_n, 1);
        mon_kind = cmd_dht ? 0 : cmd_sr04 ? 1 : cmd_rst ? 2 : 3;
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", mon_kind, -1);
        end else begin
          mon_e = exp_q.pop_front();
          check("strobe_kind", mon_kind, int'(mon_e.kind));
          check("strobe_cycle", cyc, mon_e.at);
        end
      end
    end
  end

  function automatic logic [7:0] rand_char();
    logic [7:0] pool[10];
    pool = '{"D", "H", "T", "S", "R", "d", "h", "t", "s", "r"};
    if ($urandom_range(0, 9) == 0) return 8'($urandom_range(0, 255));
    if ($urandom_range(0, 9) == 0) return 8'h20;
    return pool[$urandom_range(0, 9)];
  endfunction

  initial begin
    string cmds[3];
    string s;
    int    hold, gap;
    cmds = '{"DHT", "SR", "RST"};

    reset   = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_quiet("reset");
    reset = 1'b0;

    // Basic commands, slow receiver
    send_str("DHT", 16, 2);
    send_byte(8'h0D, 16, 2);
    send_byte(8'h0A, 16, 2);
    drain();
    check("busy_after_dht", int'(busy), 0);
    send_str("sr", 16, 1);
    send_byte(8'h0A, 16, 1);
    send_str(" R S T", 4, 1);
    send_byte(8'h0D, 4, 1);
    drain();

    // Error lines: too long, illegal byte, unknown
    send_str("DHTX1", 3, 1);
    send_byte(8'h0A, 3, 1);
    send_byte("D", 3, 1);
    send_byte(8'h01, 3, 1);
    send_byte("T", 3, 1);
    send_byte(8'h0A, 3, 1);
    send_str("SRX", 3, 1);
    send_byte(8'h0A, 3, 1);
    drain();

    // Timeout of a partial line
    send_str("DH", 3, 1);
    check("busy_partial", int'(busy), 1);
    repeat (TO + 5) @(negedge clk);
    check("busy_after_timeout", int'(busy), 0);
    send_str("RST", 3, 1);
    send_byte(8'h0A, 3, 1);
    drain();

    // Reset in the middle of a line
    send_str("DH", 3, 1);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    check_quiet("midline_reset");
    reset = 1'b0;
    send_byte("T", 3, 1);
    send_byte(8'h0A, 3, 1);
    drain();

    // Fastest possible byte rate across line boundaries
    send_str("SR", 1, 0);
    send_byte(8'h0A, 1, 0);
    send_str("DHT", 1, 0);
    send_byte(8'h0D, 1, 0);
    send_str("rst", 1, 0);
    send_byte(8'h0A, 1, 0);
    drain();

    // Randomized lines, including idle gaps around the timeout boundary
    for (int n = 0; n < 150; n++) begin
      hold = $urandom_range(1, 16);
      gap  = $urandom_range(0, 3);
      if ($urandom_range(0, 9) < 6) begin
        s = cmds[$urandom_range(0, 2)];
        for (int i = 0; i < s.len(); i++) begin
          if ($urandom_range(0, 7) == 0) send_byte(8'h20, hold, gap);
          send_byte(($urandom_range(0, 1) == 1) ? s[i] + 8'h20 : s[i], hold, gap);
          if ($urandom_range(0, 19) == 0) repeat ($urandom_range(TO - 20, TO + 3)) @(negedge clk);
        end
      end else begin
        for (int i = 0; i < int'($urandom_range(1, 6)); i++) begin
          send_byte(rand_char(), hold, gap);
          if ($urandom_range(0, 19) == 0) repeat ($urandom_range(TO - 20, TO + 3)) @(negedge clk);
        end
      end
      send_byte(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A, hold, gap);
    end

    repeat (TO + 10) @(negedge clk);
    check("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
Name: uart_cmd_parser

Overview:
Sits directly downstream of the UART receiver and consumes its byte/done outputs. Assembles received ASCII bytes into a short line, decodes the line on CR/LF, and issues one-cycle command strobes to the DHT11 and HC-SR04 controllers. Malformed lines produce an error strobe. Stale partial lines are discarded after an inactivity timeout.

Parameters:
MAX_LEN, 4, maximum command characters buffered per line, excluding the terminator.
TIMEOUT_CYC, 1_000_000, clk cycles without an accepted byte before a partial line is discarded (10 ms at 100 MHz).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
rx_data  input  8  received byte; valid while rx_done is high
rx_done  input  1  receiver done level; may stay high for many clk cycles per byte
cmd_dht  output  1  one-cycle strobe for line "DHT"
cmd_sr04  output  1  one-cycle strobe for line "SR"
cmd_rst  output  1  one-cycle strobe for line "RST"
cmd_err  output  1  one-cycle strobe for an invalid, unknown or over-long line
busy  output  1  high while a partial line is held (COLLECT or DISCARD)

Behaviour:
- Reset is clk, with reset asynchronous and active-high. Every output resets to 0, state resets to IDLE, the buffer and length reset to 0, the timeout counter resets to 0, and rx_done_d resets to 0.
- Byte accept: rx_done=1 and rx_done_d=0, where rx_done_d is a registered copy of rx_done. Only one accept happens per rx_done high period. rx_data is sampled in the accept cycle.
- Byte classification, applied in this order:
  - CR (0x0D) or LF (0x0A) is a terminator.
  - Space (0x20) is ignored.
  - 0x61..0x7A are converted to uppercase by subtracting 0x20.
  - 0x21..0x7E are printable.
  - Anything else is illegal.
- IDLE (len=0):
  - printable: store at buf[0], len=1, go to COLLECT.
  - terminator: stay in IDLE with no strobe. An empty line is silent, so CRLF works.
  - illegal: go to DISCARD.
- COLLECT:
  - printable with len<MAX_LEN: store at buf[len], len+1.
  - printable with len==MAX_LEN: go to DISCARD.
  - illegal: go to DISCARD.
  - terminator: go to DECODE.
- DISCARD:
  - ignores all bytes except terminators.
  - terminator: go to DECODE with an error flag set.
- DECODE lasts exactly one cycle.
  - Compares buf[0..len-1] against "DHT" (len 3), "SR" (len 2) and "RST" (len 3). The length must match exactly.
  - Registers exactly one strobe: the matching cmd_*, or cmd_err if there is no match or the error flag is set.
  - Clears len and the error flag, then goes to IDLE.
  - If a byte is accepted during the DECODE cycle, it is classified as the first byte of the next line, as in IDLE.
- Latency: terminator accepted in cycle T → state=DECODE in T+1 → strobe high in T+2 only. At most one strobe is high in any cycle.
- Timeout:
  - The counter increments each cycle in COLLECT or DISCARD and clears on any accept.
  - On reaching TIMEOUT_CYC-1: clear len and the error flag, go to IDLE, no strobe.
  - An accept in the same cycle wins: the counter clears and the byte is processed.
  - Counter width is $clog2(TIMEOUT_CYC).
- busy=1 exactly when state is COLLECT or DISCARD. It is combinational from state.
- Reset mid-line discards everything. No strobe is issued for the interrupted line.

Decomposition:
- Shared package uart_cmd_pkg holds:
  - ASCII constants (CR, LF, SP, lowercase range bounds, printable range bounds).
  - Command string constants and lengths for DHT, SR and RST.
  - A 2-bit command enum (NONE/DHT/SR04/RST).
  - A 2-bit state encoding (IDLE/COLLECT/DISCARD/DECODE).
- One sub-module: uart_cmd_match. It is purely combinational, takes buf and len, and returns the command enum. This keeps the string compare separate from the FSM.
- The rx_done edge detect stays inline.

Test Plan:
- Send 'D','H','T',CR,LF, with rx_done held 16 clk per byte → cmd_dht high for one cycle exactly 2 clk after the CR accept; no cmd_err; busy returns to 0; the LF produces nothing.
- Send 's','r',LF → one cmd_sr04 strobe. Send " R S T",CR → one cmd_rst strobe (spaces ignored).
- Send 'D','H','T','X','1',LF (5 chars > MAX_LEN) → only cmd_err. Send 'D',0x01,'T',LF → only cmd_err. Send 'S','R','X',LF (unknown) → only cmd_err.
- Send 'D','H', wait TIMEOUT_CYC cycles (TIMEOUT_CYC=50 in the bench) → busy drops with no strobe. Then send 'R','S','T',LF → cmd_rst only.
- Send 'D','H', assert reset mid-line, release, send 'T',LF → cmd_err only ("T" is unknown). All outputs are 0 during reset.
- Assert rx_done with the terminator so its accept lands in DECODE of the prior line → the prior strobe fires, and the new byte starts a fresh line that decodes correctly.
